// File: rtl/nios_cutecar_niveau_in.sv
// nios_cutecar_niveau_in
//
// Avalon-MM input port for the CUTECAR level bus. This is the read-side
// counterpart of the 7-bit level output port. Each input bit goes through a
// two-flop synchroniser and then a per-bit debouncer. The debounced value is
// readable by the CPU. Edges of the debounced value are captured in a
// write-1-to-clear register and can raise a maskable level interrupt.
//
// Parameters:
//   WIDTH           number of level inputs (1..32)
//   DEBOUNCE_CYCLES cycles a synchronised bit must disagree with the stable
//                   value before the new value is accepted (>= 1)
//   EDGE_TYPE       edges captured: 0 rising, 1 falling, 2 any
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     word address: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   in_port     asynchronous level inputs from the car hardware
//   readdata    combinational read data for the current address
//   irq         level interrupt, |(edgecapture & irqmask)

module nios_cutecar_niveau_in #(
    parameter int WIDTH           = 7,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise_evt;
    logic [WIDTH-1:0] fall_evt;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;

    // Only the low WIDTH bits of writedata carry register content; the rest
    // are folded here so they count as consumed.
    logic writedata_unused;
    assign writedata_unused = ^writedata;

    // Two-flop synchroniser on every level input.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    // A bit is accepted in the cycle its counter has seen DEBOUNCE_CYCLES
    // consecutive disagreements, which is exactly when stable updates.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Per-bit debouncer. Any cycle in which s2 agrees with stable restarts
    // the count, so short glitches never reach the stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // The accepted value is the new stable value, so it tells the direction.
    assign rise_evt = accept & s2;
    assign fall_evt = accept & ~s2;

    // Select which edge directions are captured.
    always_comb begin
        edge_evt = accept;
        if (EDGE_TYPE == 0) begin
            edge_evt = rise_evt;
        end else if (EDGE_TYPE == 1) begin
            edge_evt = fall_evt;
        end
    end

    assign wr_en      = chipselect && !write_n;
    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // CPU-visible registers. The new edge event is ORed in after the clear,
    // so an edge that coincides with a clear of the same bit still sticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~clear_bits) | edge_evt;
        end
    end

    // Zero-wait-state read mux; unused upper bits read as zero.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(stable);
            2'd1:    readdata = '0;
            2'd2:    readdata = 32'(irqmask);
            default: readdata = 32'(edgecapture);
        endcase
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_cutecar_niveau_in.sv
// tb_nios_cutecar_niveau_in
//
// Three copies of the input port share one bus and one in_port: one
// capturing any edge, one rising only, one falling only. The stimulus side
// drives the bus, steps a behavioural model of the port and pushes the
// expected read response of every copy into a queue. A monitor pops that
// queue whenever a read is presented and compares readdata and irq.

module tb_nios_cutecar_niveau_in;

    localparam int W = 7;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [W-1:0] in_port;

    logic [31:0]  rd_any, rd_rise, rd_fall;
    logic         irq_any, irq_rise, irq_fall;

    int checks = 0;
    int errors = 0;

    nios_cutecar_niveau_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_any), .irq(irq_any)
    );

    nios_cutecar_niveau_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_rise), .irq(irq_rise)
    );

    nios_cutecar_niveau_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_fall), .irq(irq_fall)
    );

    always #5 clk = ~clk;

    // Behavioural model: the input as seen one and two edges ago, how many
    // consecutive edges the delayed input has disagreed with the accepted
    // value, and the CPU-visible state. Index 0 any, 1 rising, 2 falling.
    logic [W-1:0] seen1, seen2;
    logic [W-1:0] m_stable, m_mask;
    logic [W-1:0] m_ec [3];
    int           m_run [W];

    typedef struct packed {
        logic [1:0]        addr;
        logic [2:0][31:0]  rd;
        logic [2:0]        irq;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    logic [W-1:0] cur_in;

    // Advance the model across one rising edge using the inputs being driven.
    task automatic modelEdge();
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] clr;
        logic         wr;
        rise = '0;
        fall = '0;
        if (reset) begin
            seen1 = '0;
            seen2 = '0;
            m_stable = '0;
            m_mask = '0;
            for (int k = 0; k < 3; k++) m_ec[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            return;
        end
        for (int i = 0; i < W; i++) begin
            if (seen2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_run[i] = 0;
                    if (seen2[i]) rise[i] = 1'b1;
                    else          fall[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_stable = m_stable ^ (rise | fall);
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        m_ec[0] = (m_ec[0] & ~clr) | rise | fall;
        m_ec[1] = (m_ec[1] & ~clr) | rise;
        m_ec[2] = (m_ec[2] & ~clr) | fall;
        seen2 = seen1;
        seen1 = in_port;
    endtask

    function automatic logic [31:0] expRead(logic [1:0] a, int k);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd1:    return 32'd0;
            2'd2:    return 32'(m_mask);
            default: return 32'(m_ec[k]);
        endcase
    endfunction

    // Drive one bus cycle, queue the expected response for reads, then step
    // the model across the next edge.
    task automatic applyStimulus(input logic rst, input logic cs, input logic wn,
                                 input logic [1:0] a, input logic [31:0] wd,
                                 input logic [W-1:0] inp);
        exp_t e;
        reset      = rst;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        in_port    = inp;
        if (!rst && cs && wn) begin
            e.addr = a;
            for (int k = 0; k < 3; k++) begin
                e.rd[k]  = expRead(a, k);
                e.irq[k] = |(m_ec[k] & m_mask);
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doRead(input logic [1:0] a);
        applyStimulus(1'b0, 1'b1, 1'b1, a, 32'h0, cur_in);
    endtask

    task automatic doWrite(input logic [1:0] a, input logic [31:0] wd);
        applyStimulus(1'b0, 1'b1, 1'b0, a, wd, cur_in);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, cur_in);
    endtask

    task automatic readCycles(input logic [1:0] a, input int n);
        for (int i = 0; i < n; i++) doRead(a);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every presented read pops one expectation.
    always @(negedge clk) begin
        if (chipselect && write_n && !reset) begin
            if (exp_q.size() == 0) begin
                checkOutput("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput($sformatf("rd_any@%0d", mon_e.addr), rd_any, mon_e.rd[0]);
                checkOutput($sformatf("rd_rise@%0d", mon_e.addr), rd_rise, mon_e.rd[1]);
                checkOutput($sformatf("rd_fall@%0d", mon_e.addr), rd_fall, mon_e.rd[2]);
                checkOutput("irq_any", 32'(irq_any), 32'(mon_e.irq[0]));
                checkOutput("irq_rise", 32'(irq_rise), 32'(mon_e.irq[1]));
                checkOutput("irq_fall", 32'(irq_fall), 32'(mon_e.irq[2]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout waiting for stimulus to complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int r;
        cur_in = '0;
        seen1 = '0;
        seen2 = '0;
        m_stable = '0;
        m_mask = '0;
        for (int k = 0; k < 3; k++) m_ec[k] = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;

        // Reset while a write is attempted; the write must not survive.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 32'h7F, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, '0);
        for (int a = 0; a < 4; a++) doRead(2'(a));

        // Level 0x05 appears on the bus after 2 + D edges.
        cur_in = 7'h05;
        readCycles(2'd0, 9);
        doRead(2'd3);
        doWrite(2'd3, 32'hFFFF_FFFF);
        doRead(2'd3);

        // Three-cycle glitch on bit 3 is rejected, four-cycle pulse accepted.
        cur_in = 7'h0D;
        readCycles(2'd0, 3);
        cur_in = 7'h05;
        readCycles(2'd3, 8);
        cur_in = 7'h0D;
        readCycles(2'd0, 4);
        cur_in = 7'h05;
        readCycles(2'd3, 8);
        doWrite(2'd3, 32'h7F);

        // Interrupt path on bit 0.
        doWrite(2'd2, 32'h01);
        cur_in = 7'h04;
        idle(D + 3);
        doWrite(2'd3, 32'h7F);
        cur_in = 7'h05;
        readCycles(2'd3, D + 3);
        doWrite(2'd3, 32'h02);
        readCycles(2'd3, 2);
        doWrite(2'd3, 32'h01);
        readCycles(2'd3, 2);

        // Clear on bit 6 lands on the very edge bit 6 becomes stable.
        cur_in = 7'h45;
        idle(D + 1);
        doWrite(2'd3, 32'h40);
        readCycles(2'd3, 2);
        doWrite(2'd3, 32'h7F);

        // Bit 2 falls then rises: each direction captured by its own copy.
        cur_in = 7'h41;
        readCycles(2'd3, D + 3);
        doWrite(2'd3, 32'h7F);
        cur_in = 7'h45;
        readCycles(2'd3, D + 3);
        doWrite(2'd3, 32'h7F);

        // Reset in the middle of a pending debounce.
        cur_in = 7'h55;
        idle(D + 3);
        doWrite(2'd2, 32'h7F);
        doRead(2'd3);
        cur_in = 7'h57;
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, cur_in);
        for (int a = 0; a < 4; a++) doRead(2'(a));
        readCycles(2'd0, D + 3);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(9) == 0) cur_in = W'($urandom);
            else if ($urandom_range(11) == 0) cur_in = cur_in ^ W'(1 << $urandom_range(W - 1));
            r = $urandom_range(99);
            if (r < 2)
                applyStimulus(1'b1, 1'($urandom_range(1)), 1'b0, 2'($urandom_range(3)),
                              $urandom, cur_in);
            else if (r < 55)
                doRead(2'($urandom_range(3)));
            else if (r < 72)
                doWrite(2'($urandom_range(3)), $urandom);
            else if (r < 80)
                applyStimulus(1'b0, 1'b0, 1'b0, 2'($urandom_range(3)), $urandom, cur_in);
            else
                idle(1);
        end

        idle(3);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_cutecar_niveau_in.md
# nios_cutecar_niveau_in

Avalon-MM input port on the CUTECAR Nios system bus: the read-side counterpart of the 7-bit level output port. It samples a 7-bit level bus from the car hardware, synchronises and debounces each bit, and exposes the stable value to the CPU. Per-bit edge capture and a maskable interrupt let firmware react to level changes without polling.

## Interface

Parameters:
- WIDTH, 7, number of input bits (1..32).
- DEBOUNCE_CYCLES, 1000, clock cycles a synchronised bit must differ from its stable value before the change is accepted; must be ≥1.
- EDGE_TYPE, 2, edges to capture: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous level inputs from car hardware.
- readdata  out  32  combinational read data for the current address.
- irq  out  1  active-high interrupt, level.

## Operation

- Synchronizer: two flops per bit (s1, s2); reset to 0.
- Debounce, per bit, counter cnt (width clog2(DEBOUNCE_CYCLES)+1):
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 resets cnt and is never seen.
- Edge event: asserted for bit i in the cycle stable[i] updates.
  - Rising: new value 1.
  - Falling: new value 0.
  - EDGE_TYPE selects which events count.
- Register map (word addresses):
  - 0: data. Read {0, stable}; writes ignored.
  - 1: reserved. Reads 0; writes ignored.
  - 2: irqmask. R/W bits [WIDTH-1:0]; upper bits read 0.
  - 3: edgecapture. Read captured bits. Write-1-to-clear: a write clears bit i where writedata[i]=1.
- Write acceptance: chipselect && !write_n, at the clock edge.
- Simultaneous edge event and clear on the same bit in the same cycle: set wins, bit stays 1.
- irq = |(edgecapture & irqmask), combinational from registers.

## Timing

- Reset values (all cleared at the clk edge where reset=1): s1, s2, stable, cnt, irqmask and edgecapture are 0. readdata is 0 at every address, and irq is 0.
- Reset overrides any concurrent bus write. Reset mid-debounce discards the pending change.
- Input-to-stable latency: 2 + DEBOUNCE_CYCLES rising edges after in_port changes, assuming the input is held steady.
- edgecapture updates on the same edge as stable. irq follows combinationally in that same cycle if the bit is masked in.
- readdata has zero wait states and is combinational from address; register effects of a write are visible on the next cycle.
- After reset, an input held high produces a rising edge event after 2 + DEBOUNCE_CYCLES cycles. This is intended behaviour; firmware clears edgecapture after init.
- Mask change takes effect on irq the cycle after the write.

## Test plan

- DEBOUNCE_CYCLES=4, EDGE_TYPE=2: reset, then in_port 0x00→0x05 held.
  - Addr 0 reads 0x00000000 through cycle 5 and 0x00000005 from cycle 6.
  - Addr 3 reads 0x05.
- Glitch rejection: bit 3 pulses high for 3 cycles at s2 with DEBOUNCE_CYCLES=4 → stable and edgecapture stay 0x00. A 4-cycle pulse is accepted and sets edgecapture bit 3.
- IRQ path: write irqmask=0x01, toggle bit 0 low→high.
  - irq rises the cycle stable[0] goes 1.
  - Write 0x01 to addr 3: edgecapture reads 0 and irq drops the next cycle.
  - Writing 0x02 instead leaves irq high.
- Set/clear collision: write 0x40 to addr 3 on the same cycle bit 6 stable updates → edgecapture[6] reads 1 afterwards.
- EDGE_TYPE=0: bit 2 goes 1 then back to 0 → only the rise is captured; after clearing, the fall leaves edgecapture 0x00.
- Reset mid-operation: assert reset 2 cycles into a pending debounce with irqmask=0x7F and edgecapture=0x10.
  - Next cycle all registers and irq read 0.
  - The input change is then re-debounced from scratch, taking the full 2 + DEBOUNCE_CYCLES latency.
